// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
//   Time-of-day core and key-driven set-mode sequencer for the digital clock.
//   In RUN the HH:MM:SS counter advances on every tick_1hz. A mode key steps
//   through SET_HR -> SET_MIN -> SET_SEC -> RUN. While a field is selected,
//   time is frozen, inc/dec keys edit that field with wrap-around, and ticks
//   only drive the blink phase and the idle timeout back to RUN.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   tick_1hz   in   one-cycle pulse, once per second
//   key_mode   in   one-cycle pulse: advance edit field
//   key_inc    in   one-cycle pulse: increment selected field
//   key_dec    in   one-cycle pulse: decrement selected field
//   hour       out  hours 0..23
//   min        out  minutes 0..59
//   sec        out  seconds 0..59
//   edit_field out  0=none(RUN) 1=hour 2=min 3=sec
//   set_active out  1 in any SET state
//   blink      out  blank phase for the selected field; 0 in RUN
// ---------------------------------------------------------------------------
module time_set_ctrl #(
  parameter int unsigned TIMEOUT_S = 10  // idle seconds before auto-return (1..63)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] edit_field,
  output logic       set_active,
  output logic       blink
);

  // The encoding doubles as the edit_field value.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_SEC = 2'd3
  } state_e;

  localparam logic [5:0] IDLE_LAST = 6'(TIMEOUT_S - 1);

  state_e     state_q, state_d;
  logic [4:0] hour_q,  hour_d;
  logic [5:0] min_q,   min_d;
  logic [5:0] sec_q,   sec_d;
  logic [5:0] idle_q,  idle_d;
  logic       blink_q, blink_d;

  logic step_up, step_dn, edit_key, timeout;

  // Compare-then-wrap keeps every field inside its legal range.
  function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max);
    return (val >= max) ? 6'd0 : val + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] val, input logic [5:0] max);
    return (val == 6'd0 || val > max) ? max : val - 6'd1;
  endfunction

  // inc and dec together cancel, but both still count as key activity.
  assign step_up  = key_inc & ~key_dec;
  assign step_dn  = key_dec & ~key_inc;
  assign edit_key = key_inc | key_dec;
  // A pending inc/dec clears the idle count, so it also suppresses the timeout.
  assign timeout  = tick_1hz & ~edit_key & (idle_q == IDLE_LAST);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    idle_d  = idle_q;
    blink_d = blink_q;

    unique case (state_q)
      ST_RUN: begin
        idle_d  = 6'd0;
        blink_d = 1'b0;
        if (tick_1hz) begin
          sec_d = wrap_inc(sec_q, 6'd59);
          if (sec_q == 6'd59) begin
            min_d = wrap_inc(min_q, 6'd59);
            if (min_q == 6'd59) begin
              hour_d = 5'(wrap_inc({1'b0, hour_q}, 6'd23));
            end
          end
        end
        if (key_mode) begin
          state_d = ST_SET_HR;
          blink_d = 1'b1;
        end
      end

      default: begin
        if (key_mode) begin
          // Mode wins over inc/dec and over a coincident timeout.
          unique case (state_q)
            ST_SET_HR:  state_d = ST_SET_MIN;
            ST_SET_MIN: state_d = ST_SET_SEC;
            default:    state_d = ST_RUN;
          endcase
          idle_d  = 6'd0;
          blink_d = (state_d != ST_RUN);
        end else if (timeout) begin
          state_d = ST_RUN;
          idle_d  = 6'd0;
          blink_d = 1'b0;
        end else begin
          if (edit_key) begin
            idle_d = 6'd0;
          end else if (tick_1hz) begin
            idle_d = idle_q + 6'd1;
          end
          if (tick_1hz) begin
            blink_d = ~blink_q;
          end
          unique case (state_q)
            ST_SET_HR: begin
              if (step_up) hour_d = 5'(wrap_inc({1'b0, hour_q}, 6'd23));
              if (step_dn) hour_d = 5'(wrap_dec({1'b0, hour_q}, 6'd23));
            end
            ST_SET_MIN: begin
              if (step_up) min_d = wrap_inc(min_q, 6'd59);
              if (step_dn) min_d = wrap_dec(min_q, 6'd59);
            end
            default: begin
              if (step_up) sec_d = wrap_inc(sec_q, 6'd59);
              if (step_dn) sec_d = wrap_dec(sec_q, 6'd59);
            end
          endcase
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      hour_q  <= 5'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      idle_q  <= 6'd0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      idle_q  <= idle_d;
      blink_q <= blink_d;
    end
  end

  assign hour       = hour_q;
  assign min        = min_q;
  assign sec        = sec_q;
  assign edit_field = state_q;
  assign set_active = (state_q != ST_RUN);
  assign blink      = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_time_set_ctrl
//   Self-checking bench for time_set_ctrl. A reference model holds the time
//   as plain integers (seconds-of-day arithmetic in RUN, modular field edits
//   in SET) and is stepped alongside the DUT one clock at a time.
// ---------------------------------------------------------------------------
module tb_time_set_ctrl;

  localparam int TIMEOUT_S = 10;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, key_mode, key_inc, key_dec;
  logic [4:0] hour;
  logic [5:0] min, sec;
  logic [1:0] edit_field;
  logic       set_active, blink;

  time_set_ctrl #(.TIMEOUT_S(TIMEOUT_S)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .key_mode   (key_mode),
    .key_inc    (key_inc),
    .key_dec    (key_dec),
    .hour       (hour),
    .min        (min),
    .sec        (sec),
    .edit_field (edit_field),
    .set_active (set_active),
    .blink      (blink)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_h, m_m, m_s, m_st, m_bl, m_idle;

  logic [20:0] dut_vec;
  assign dut_vec = {hour, min, sec, edit_field, set_active, blink};

  function automatic logic [20:0] exp_vec();
    return {5'(m_h), 6'(m_m), 6'(m_s), 2'(m_st), 1'(m_st != 0), 1'(m_bl)};
  endfunction

  task automatic model_step(input bit r, input bit md, input bit ic, input bit dc, input bit tk);
    int t, modv;
    if (r) begin
      m_h = 0; m_m = 0; m_s = 0; m_st = 0; m_bl = 0; m_idle = 0;
    end else if (m_st == 0) begin
      if (tk) begin
        t   = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
        m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
      end
      if (md) begin m_st = 1; m_bl = 1; end
      m_idle = 0;
    end else if (md) begin
      m_st = (m_st + 1) % 4; m_idle = 0; m_bl = (m_st != 0);
    end else if (tk && !ic && !dc && m_idle == TIMEOUT_S - 1) begin
      m_st = 0; m_idle = 0; m_bl = 0;
    end else begin
      if (ic || dc) m_idle = 0;
      else if (tk)  m_idle++;
      if (tk) m_bl = !m_bl;
      if (ic != dc) begin
        modv = (m_st == 1) ? 24 : 60;
        case (m_st)
          1: m_h = (m_h + (ic ? 1 : modv - 1)) % modv;
          2: m_m = (m_m + (ic ? 1 : modv - 1)) % modv;
          default: m_s = (m_s + (ic ? 1 : modv - 1)) % modv;
        endcase
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, sample 1 ns later.
  task automatic cyc(input bit r, input bit md, input bit ic, input bit dc, input bit tk);
    rst = r; key_mode = md; key_inc = ic; key_dec = dc; tick_1hz = tk;
    @(posedge clk);
    #1;
    rst = 0; key_mode = 0; key_inc = 0; key_dec = 0; tick_1hz = 0;
    model_step(r, md, ic, dc, tk);
  endtask

  // Walks SET_HR/MIN/SEC with inc keys to reach h:m:s, ends back in RUN.
  task automatic set_time(input int h, input int m, input int s);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 24 && m_h != h; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 60 && m_m != m; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 60 && m_s != s; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 1, 0, 1);
    n_checks++;
    if (dut_vec !== 21'd0) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec, 21'd0);
    end
  endtask

  task automatic test_run_count();
    for (int i = 0; i < 3661; i++) cyc(0, 0, 0, 0, 1);
    n_checks++;
    if ({hour, min, sec} !== {5'd1, 6'd1, 6'd1} || edit_field !== 2'd0) begin
      n_fail++; $display("FAIL run_3661: got %0d:%0d:%0d ef=%0d expected 1:1:1 ef=0",
                         hour, min, sec, edit_field);
    end
  endtask

  task automatic test_rollover();
    set_time(23, 59, 59);
    n_checks++;
    if ({hour, min, sec, edit_field} !== {5'd23, 6'd59, 6'd59, 2'd0}) begin
      n_fail++; $display("FAIL preset: got %0d:%0d:%0d ef=%0d expected 23:59:59 ef=0",
                         hour, min, sec, edit_field);
    end
    cyc(0, 0, 0, 0, 1);
    n_checks++;
    if (dut_vec !== 21'd0) begin
      n_fail++; $display("FAIL midnight_wrap: got %h expected %h", dut_vec, 21'd0);
    end
  endtask

  task automatic test_run_ignores_keys();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
    n_checks++;
    if ({hour, min, sec, edit_field} !== {5'd0, 6'd0, 6'd2, 2'd0}) begin
      n_fail++; $display("FAIL run_inc_ignored: got %0d:%0d:%0d expected 0:0:2",
                         hour, min, sec);
    end
    cyc(0, 1, 0, 0, 0);
    n_checks++;
    if ({edit_field, set_active, blink} !== 4'b0111) begin
      n_fail++; $display("FAIL enter_set_hr: got ef=%0d sa=%0b bl=%0b expected ef=1 sa=1 bl=1",
                         edit_field, set_active, blink);
    end
  endtask

  task automatic test_field_wrap();
    // Now in SET_HR at 00:00:02.
    cyc(0, 0, 0, 1, 0);
    n_checks++;
    if (hour !== 5'd23) begin n_fail++; $display("FAIL hour_dec_wrap: got %0d expected 23", hour); end
    cyc(0, 0, 1, 0, 0);
    n_checks++;
    if (hour !== 5'd0) begin n_fail++; $display("FAIL hour_inc_wrap: got %0d expected 0", hour); end
    cyc(0, 0, 0, 1, 0);
    n_checks++;
    if (hour !== 5'd23) begin n_fail++; $display("FAIL hour_dec_again: got %0d expected 23", hour); end
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    n_checks++;
    if ({hour, min, edit_field} !== {5'd23, 6'd59, 2'd2}) begin
      n_fail++; $display("FAIL min_dec_wrap: got h=%0d m=%0d ef=%0d expected h=23 m=59 ef=2",
                         hour, min, edit_field);
    end
  endtask

  task automatic test_timeout();
    // In SET_MIN at 23:59:02, idle count cleared by the last key.
    for (int i = 0; i < TIMEOUT_S - 1; i++) cyc(0, 0, 0, 0, 1);
    n_checks++;
    if ({hour, min, sec, edit_field} !== {5'd23, 6'd59, 6'd2, 2'd2}) begin
      n_fail++; $display("FAIL frozen_9_ticks: got %0d:%0d:%0d ef=%0d expected 23:59:2 ef=2",
                         hour, min, sec, edit_field);
    end
    cyc(0, 0, 1, 0, 0);  // key restarts the idle count; min wraps to 0
    for (int i = 0; i < TIMEOUT_S - 1; i++) cyc(0, 0, 0, 0, 1);
    n_checks++;
    if ({min, edit_field} !== {6'd0, 2'd2}) begin
      n_fail++; $display("FAIL key_restarts_idle: got m=%0d ef=%0d expected m=0 ef=2", min, edit_field);
    end
    cyc(0, 0, 0, 0, 1);
    n_checks++;
    if ({hour, min, sec, edit_field, set_active, blink} !== {5'd23, 6'd0, 6'd2, 2'd0, 2'b00}) begin
      n_fail++; $display("FAIL timeout_to_run: got %0d:%0d:%0d ef=%0d sa=%0b bl=%0b expected 23:0:2 RUN",
                         hour, min, sec, edit_field, set_active, blink);
    end
  endtask

  task automatic test_simultaneous();
    cyc(0, 1, 0, 0, 0);          // SET_HR
    cyc(0, 1, 1, 0, 0);          // mode + inc: advance only
    n_checks++;
    if ({hour, edit_field} !== {5'd23, 2'd2}) begin
      n_fail++; $display("FAIL mode_beats_inc: got h=%0d ef=%0d expected h=23 ef=2", hour, edit_field);
    end
    cyc(0, 0, 1, 1, 0);          // inc + dec: no change
    n_checks++;
    if (dut_vec !== exp_vec() || min !== 6'd0) begin
      n_fail++; $display("FAIL inc_dec_cancel: got %h expected %h", dut_vec, exp_vec());
    end
    cyc(0, 1, 0, 0, 0);          // SET_SEC
    cyc(0, 1, 0, 0, 1);          // back to RUN with a tick: no advance
    n_checks++;
    if ({sec, edit_field, blink} !== {6'd2, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL exit_tick_no_advance: got s=%0d ef=%0d bl=%0b expected s=2 ef=0 bl=0",
                         sec, edit_field, blink);
    end
  endtask

  task automatic test_reset_mid_edit();
    set_time(12, 34, 56);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);          // SET_SEC at 12:34:56
    n_checks++;
    if ({hour, min, sec, edit_field} !== {5'd12, 6'd34, 6'd56, 2'd3}) begin
      n_fail++; $display("FAIL set_sec_preset: got %0d:%0d:%0d ef=%0d expected 12:34:56 ef=3",
                         hour, min, sec, edit_field);
    end
    cyc(1, 0, 0, 0, 1);
    n_checks++;
    if (dut_vec !== 21'd0) begin
      n_fail++; $display("FAIL reset_mid_edit: got %h expected %h", dut_vec, 21'd0);
    end
    cyc(1, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0);
    n_checks++;
    if (dut_vec !== 21'd0) begin
      n_fail++; $display("FAIL ticks_during_rst: got %h expected %h", dut_vec, 21'd0);
    end
  endtask

  task automatic test_random();
    bit r, md, ic, dc, tk;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 999) == 0);
      md = ($urandom_range(0, 15) == 0);
      ic = ($urandom_range(0, 3) == 0);
      dc = ($urandom_range(0, 5) == 0);
      tk = ($urandom_range(0, 2) == 0);
      cyc(r, md, ic, dc, tk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1; tick_1hz = 0; key_mode = 0; key_inc = 0; key_dec = 0;
    m_h = 0; m_m = 0; m_s = 0; m_st = 0; m_bl = 0; m_idle = 0;
    test_reset();
    test_run_count();
    test_rollover();
    test_run_ignores_keys();
    test_field_wrap();
    test_timeout();
    test_simultaneous();
    test_reset_mid_edit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
